// File: rtl/flot_pkg.sv
// Shared constants, FSM encoding and exponent helpers for the iterative float units.
package flot_pkg;

   localparam int unsigned FLOT_WIDTH     = 32;
   localparam int unsigned FLOT_WIDTH_EXP = 8;
   localparam int unsigned FLOT_WIDTH_MAT = 23;

   typedef enum logic [1:0] {
      StIdle,
      StDiv,
      StNorm,
      StDone
   } state_e;

   function automatic int unsigned exp_bias(input int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   function automatic int unsigned exp_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/mant_div_seq.sv
// Restoring shift-subtract mantissa divider: one quotient bit per cycle, WIDTH_mat+2 bits total.
module mant_div_seq
   import flot_pkg::*;
#(
   parameter int unsigned WIDTH_mat = FLOT_WIDTH_MAT
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               start_i,
   input  logic [WIDTH_mat:0] dividend_i,
   input  logic [WIDTH_mat:0] divisor_i,
   output logic               done_o,
   output logic [WIDTH_mat+1:0] quotient_o
);

   localparam int unsigned NUM_ITER = WIDTH_mat + 2;
   localparam int unsigned CW       = $clog2(NUM_ITER + 1);
   localparam logic [CW-1:0] LAST   = CW'(NUM_ITER - 1);

   logic [WIDTH_mat+1:0] rem_q, rem_d;
   logic [WIDTH_mat+1:0] q_q, q_d;
   logic [WIDTH_mat:0]   dvs_q, dvs_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic [WIDTH_mat:0]   diff;

   always_comb begin
      rem_d  = rem_q;
      q_d    = q_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      // rem < 2*dvs holds throughout, so rem-dvs fits in WIDTH_mat+1 bits
      diff   = rem_q[WIDTH_mat:0] - dvs_q;
      if (start_i) begin
         rem_d  = {1'b0, dividend_i};
         dvs_d  = divisor_i;
         q_d    = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (rem_q >= {1'b0, dvs_q}) begin
            q_d   = {q_q[WIDTH_mat:0], 1'b1};
            rem_d = {diff, 1'b0};
         end else begin
            q_d   = {q_q[WIDTH_mat:0], 1'b0};
            rem_d = {rem_q[WIDTH_mat:0], 1'b0};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) busy_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         rem_q  <= '0;
         q_q    <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         q_q    <= q_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign done_o     = busy_q && (cnt_q == LAST);
   assign quotient_o = q_q;

endmodule

// File: rtl/flot_div_iter.sv
// Iterative float divider: FSM, sign/exponent path, special cases and valid/ready handshake.
module flot_div_iter
   import flot_pkg::*;
#(
   parameter int unsigned WIDTH     = FLOT_WIDTH,
   parameter int unsigned WIDTH_exp = FLOT_WIDTH_EXP,
   parameter int unsigned WIDTH_mat = FLOT_WIDTH_MAT
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] OP_A,
   input  logic [WIDTH-1:0] OP_B,
   input  logic             exce_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             exce_out
);

   localparam int unsigned EW             = WIDTH_exp + 2;
   localparam logic [EW-1:0] BIAS_E       = EW'(exp_bias(WIDTH_exp));
   localparam logic [EW-1:0] EMAX_E       = EW'(exp_max(WIDTH_exp));
   localparam logic [WIDTH_exp-1:0] EXP_1 = '1;

   state_e               state_q, state_d;
   logic                 sign_q, sign_d;
   logic [WIDTH_exp-1:0] ea_q, ea_d, eb_q, eb_d;
   logic                 xin_q, xin_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 exce_q, exce_d;

   logic                 start;
   logic                 div_done;
   logic [WIDTH_mat+1:0] quot;
   logic [EW-1:0]        e_norm;
   logic [WIDTH_mat-1:0] mat_norm;

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = res_q;
   assign exce_out  = exce_q;
   assign start     = in_valid && in_ready;

   mant_div_seq #(
      .WIDTH_mat (WIDTH_mat)
   ) u_mant_div (
      .CLK        (CLK),
      .nRST       (nRST),
      .start_i    (start),
      .dividend_i ({1'b1, OP_A[WIDTH_mat-1:0]}),
      .divisor_i  ({1'b1, OP_B[WIDTH_mat-1:0]}),
      .done_o     (div_done),
      .quotient_o (quot)
   );

   // Quotient lies in (0.5, 2); a clear MSB means one left shift and exponent-1.
   always_comb begin
      e_norm   = {2'b00, ea_q} - {2'b00, eb_q} + BIAS_E - EW'(!quot[WIDTH_mat+1]);
      mat_norm = quot[WIDTH_mat+1] ? quot[WIDTH_mat:1] : quot[WIDTH_mat-1:0];
   end

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      ea_d    = ea_q;
      eb_d    = eb_q;
      xin_d   = xin_q;
      res_d   = res_q;
      exce_d  = exce_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sign_d  = OP_A[WIDTH-1] ^ OP_B[WIDTH-1];
               ea_d    = OP_A[WIDTH-2 -: WIDTH_exp];
               eb_d    = OP_B[WIDTH-2 -: WIDTH_exp];
               xin_d   = exce_in;
               state_d = StDiv;
            end
         end
         StDiv: begin
            if (div_done) state_d = StNorm;
         end
         StNorm: begin
            exce_d = xin_q | (ea_q == EXP_1) | (eb_q == EXP_1);
            if (eb_q == '0) begin
               res_d  = {sign_q, EXP_1, {WIDTH_mat{1'b0}}};
               exce_d = 1'b1;
            end else if (ea_q == '0) begin
               res_d = {sign_q, {WIDTH_exp{1'b0}}, {WIDTH_mat{1'b0}}};
            end else if (!e_norm[EW-1] && (e_norm >= EMAX_E)) begin
               res_d  = {sign_q, EXP_1, {WIDTH_mat{1'b0}}};
               exce_d = 1'b1;
            end else if (e_norm[EW-1] || (e_norm == '0)) begin
               res_d  = {sign_q, {WIDTH_exp{1'b0}}, {WIDTH_mat{1'b0}}};
               exce_d = 1'b1;
            end else begin
               res_d = {sign_q, e_norm[WIDTH_exp-1:0], mat_norm};
            end
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= StIdle;
         sign_q  <= 1'b0;
         ea_q    <= '0;
         eb_q    <= '0;
         xin_q   <= 1'b0;
         res_q   <= '0;
         exce_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         ea_q    <= ea_d;
         eb_q    <= eb_d;
         xin_q   <= xin_d;
         res_q   <= res_d;
         exce_q  <= exce_d;
      end
   end

endmodule

// File: tb/tb_flot_div_iter.sv
// Directed and randomized checks of flot_div_iter against an integer-division reference model.
module tb_flot_div_iter;

   logic        CLK;
   logic        nRST;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] OP_A;
   logic [31:0] OP_B;
   logic        exce_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        exce_out;

   int n_cmp = 0;
   int n_bad = 0;

   flot_div_iter dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .OP_A      (OP_A),
      .OP_B      (OP_B),
      .exce_in   (exce_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .exce_out  (exce_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      assert (obs === want)
      else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   // Reference: mantissa quotient as a plain truncated integer division of hidden-1 significands.
   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic xin);
      int          ea, eb, e;
      logic        s, x;
      logic [47:0] num, den, q;
      logic [22:0] mat;
      logic [31:0] r;
      s   = a[31] ^ b[31];
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      num = 48'({1'b1, a[22:0]}) << 24;
      den = 48'({1'b1, b[22:0]});
      q   = num / den;
      if (q[24]) begin
         mat = q[23:1];
         e   = ea - eb + 127;
      end else begin
         mat = q[22:0];
         e   = ea - eb + 126;
      end
      x = xin || (ea == 255) || (eb == 255);
      if (eb == 0) begin
         r = {s, 8'hFF, 23'd0};
         x = 1'b1;
      end else if (ea == 0) begin
         r = {s, 31'd0};
      end else if (e >= 255) begin
         r = {s, 8'hFF, 23'd0};
         x = 1'b1;
      end else if (e <= 0) begin
         r = {s, 31'd0};
         x = 1'b1;
      end else begin
         r = {s, e[7:0], mat};
      end
      return {x, r};
   endfunction

   // One full transaction: accept, latency, result, optional back-pressure hold, release.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic xin,
                         input int hold, input logic [32:0] want, input string tag);
      int n;
      in_valid = 1'b1;
      OP_A     = a;
      OP_B     = b;
      exce_in  = xin;
      chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      OP_A     = $urandom;
      OP_B     = $urandom;
      exce_in  = 1'($urandom_range(0, 1));
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'd26);
      chk({tag, " result"}, 64'({exce_out, result}), 64'(want));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         OP_A     = $urandom;
         OP_B     = $urandom;
         step();
         chk({tag, " hold"}, 64'({in_ready, out_valid, exce_out, result}),
             64'({1'b0, 1'b1, want}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " release"}, 64'({in_ready, out_valid}), 64'(2'b10));
   endtask

   initial begin
      logic [31:0] a, b;
      logic        xin;
      nRST      = 1'b0;
      in_valid  = 1'b0;
      OP_A      = '0;
      OP_B      = '0;
      exce_in   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      chk("reset", 64'({in_ready, out_valid, exce_out, result}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
      nRST = 1'b1;
      step();

      run_op(32'h40C00000, 32'h40000000, 1'b0, 0, {1'b0, 32'h40400000}, "6/2");
      run_op(32'h3F800000, 32'h40400000, 1'b0, 0, {1'b0, 32'h3EAAAAAA}, "1/3");
      run_op(32'hBFC00000, 32'h3F000000, 1'b0, 0, {1'b0, 32'hC0400000}, "neg");
      run_op(32'h80000000, 32'h3F800000, 1'b0, 0, {1'b0, 32'h80000000}, "negzero");
      run_op(32'h40C00000, 32'h00000000, 1'b0, 0, {1'b1, 32'h7F800000}, "divzero");
      run_op(32'h7F000000, 32'h00800000, 1'b0, 0, {1'b1, 32'h7F800000}, "ovf");
      run_op(32'h00800000, 32'h7F000000, 1'b0, 0, {1'b1, 32'h00000000}, "unf");
      run_op(32'h40C00000, 32'h40000000, 1'b1, 0, {1'b1, 32'h40400000}, "exce_in");
      run_op(32'h3F800000, 32'h40400000, 1'b0, 10, {1'b0, 32'h3EAAAAAA}, "backpressure");

      // Abort mid-division: reset lands at iteration 10 and no result may appear.
      in_valid = 1'b1;
      OP_A     = 32'h3F800000;
      OP_B     = 32'h40400000;
      exce_in  = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      nRST = 1'b0;
      step();
      chk("midreset", 64'({in_ready, out_valid, exce_out, result}),
          64'({1'b1, 1'b0, 1'b0, 32'h0}));
      nRST = 1'b1;
      repeat (30) step();
      chk("midreset idle", 64'({in_ready, out_valid}), 64'(2'b10));
      run_op(32'h40C00000, 32'h40000000, 1'b0, 0, {1'b0, 32'h40400000}, "after reset");

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = $urandom;
            b = $urandom;
         end else begin
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 195)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 195)), 23'($urandom)};
         end
         xin = ($urandom_range(0, 7) == 0);
         run_op(a, b, xin, $urandom_range(0, 3), ref_div(a, b, xin), $sformatf("rand%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
